// File: rtl/alu_pkg.sv
// alu_pkg: ALU op encodings, main-decoder ALUOp classes and R-type funct codes
package alu_pkg;
    localparam logic [2:0] ALU_AND   = 3'b000;
    localparam logic [2:0] ALU_OR    = 3'b001;
    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b110;
    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [3:0] F_ADD     = 4'b0000;
    localparam logic [3:0] F_SUB     = 4'b1000;
    localparam logic [3:0] F_AND     = 4'b0111;
    localparam logic [3:0] F_OR      = 4'b0110;
endpackage

// File: rtl/alu_ctrl.sv
// alu_ctrl: maps ALUOp and {funct7[5], funct3} to the 3-bit ALU op.
// Unknown encodings fall back to ADD and raise err so the instruction still flows.
module alu_ctrl
    import alu_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [3:0] funct,
    output logic [2:0] op,
    output logic       err
);
    always_comb begin
        op  = ALU_ADD;
        err = 1'b0;
        case (aluop)
            ALUOP_MEM: op = ALU_ADD;
            ALUOP_BR:  op = ALU_SUB;
            ALUOP_R: begin
                case (funct)
                    F_ADD:   op = ALU_ADD;
                    F_SUB:   op = ALU_SUB;
                    F_AND:   op = ALU_AND;
                    F_OR:    op = ALU_OR;
                    default: err = 1'b1;
                endcase
            end
            default: err = 1'b1;
        endcase
    end
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX and EX/WB registers around an external combinational ALU,
// with valid/ready handshakes on both sides and one op per cycle throughput.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_aluop,
    input  logic [3:0]       in_funct,
    input  logic             in_alusrc,
    input  logic [WIDTH-1:0] in_rs1,
    input  logic [WIDTH-1:0] in_rs2,
    input  logic [WIDTH-1:0] in_imm,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_z,
    input  logic             alu_ex,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_err
);
    logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic [2:0]       op_q, op_d;
    logic             err1_q, err1_d, zero_q, zero_d, err2_q, err2_d;
    logic [2:0]       dec_op;
    logic             dec_err, s2_free, s1_adv;

    alu_ctrl u_ctrl (
        .aluop (in_aluop),
        .funct (in_funct),
        .op    (dec_op),
        .err   (dec_err)
    );

    assign s2_free    = !s2_valid_q || out_ready;
    assign s1_adv     = s1_valid_q && s2_free;
    assign in_ready   = !s1_valid_q || s2_free;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_op     = op_q;
    assign out_valid  = s2_valid_q;
    assign out_result = result_q;
    assign out_zero   = zero_q;
    assign out_err    = err2_q;

    always_comb begin
        s1_valid_d = s1_valid_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        err1_d     = err1_q;
        s2_valid_d = s2_valid_q;
        result_d   = result_q;
        zero_d     = zero_q;
        err2_d     = err2_q;
        if (in_valid && in_ready) begin
            s1_valid_d = 1'b1;
            a_d        = in_rs1;
            b_d        = in_alusrc ? in_imm : in_rs2;
            op_d       = dec_op;
            err1_d     = dec_err;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
        // Stage 2 samples the ALU output while stage 1 still presents the operands
        if (s1_adv) begin
            s2_valid_d = 1'b1;
            result_d   = alu_z;
            zero_d     = alu_ex;
            err2_d     = err1_q;
        end else if (s2_valid_q && out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= ALU_ADD;
            err1_q     <= 1'b0;
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            err2_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            err1_q     <= err1_d;
            s2_valid_q <= s2_valid_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            err2_q     <= err2_d;
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed vectors against alu_issue_stage with a behavioural ALU
// closing the loop; inputs driven and outputs checked on the falling edge.
module tb_alu_issue_stage;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, in_alusrc, alu_ex, out_valid, out_ready;
    logic        out_zero, out_err;
    logic [1:0]  in_aluop;
    logic [3:0]  in_funct;
    logic [2:0]  alu_op;
    logic [31:0] in_rs1, in_rs2, in_imm, alu_a, alu_b, alu_z, out_result;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    assign alu_z  = alu_op == 3'b000 ? (alu_a & alu_b) :
                    alu_op == 3'b001 ? (alu_a | alu_b) :
                    alu_op == 3'b110 ? (alu_a - alu_b) : (alu_a + alu_b);
    assign alu_ex = alu_z == 32'h0;

    alu_issue_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_aluop(in_aluop), .in_funct(in_funct), .in_alusrc(in_alusrc),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_z(alu_z), .alu_ex(alu_ex),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_zero(out_zero), .out_err(out_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] aluop, input logic [3:0] funct, input logic alusrc,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
        in_valid  = 1'b1;
        in_aluop  = aluop;
        in_funct  = funct;
        in_alusrc = alusrc;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm    = imm;
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(2'b10, 4'b1000, 1'b0, 32'h55, 32'h11, 32'h0);
        step();
        step();
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_in_ready", {31'b0, in_ready}, 32'h1);
        check("rst_alu_op", {29'b0, alu_op}, 32'h2);
        check("rst_alu_a", alu_a, 32'h0);
        check("rst_alu_b", alu_b, 32'h0);
        check("rst_result", out_result, 32'h0);
        check("rst_zero", {31'b0, out_zero}, 32'h0);
        check("rst_err", {31'b0, out_err}, 32'h0);

        rst_n = 1'b1;
        drive(2'b10, 4'b1000, 1'b0, 32'h5, 32'h3, 32'h0);
        step();
        in_valid = 1'b0;
        check("sub_alu_op", {29'b0, alu_op}, 32'h6);
        check("sub_alu_a", alu_a, 32'h5);
        check("sub_alu_b", alu_b, 32'h3);
        check("sub_not_yet_valid", {31'b0, out_valid}, 32'h0);
        step();
        check("sub_valid", {31'b0, out_valid}, 32'h1);
        check("sub_result", out_result, 32'h2);
        check("sub_zero", {31'b0, out_zero}, 32'h0);
        check("sub_err", {31'b0, out_err}, 32'h0);

        drive(2'b01, 4'b0000, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0);
        step();
        in_valid = 1'b0;
        step();
        check("br_result", out_result, 32'h0);
        check("br_zero", {31'b0, out_zero}, 32'h1);

        drive(2'b00, 4'b0000, 1'b1, 32'hFFFFFFFF, 32'h1234, 32'h1);
        step();
        in_valid = 1'b0;
        check("imm_alu_b", alu_b, 32'h1);
        step();
        check("imm_result", out_result, 32'h0);
        check("imm_zero", {31'b0, out_zero}, 32'h1);
        step();
        check("drained", {31'b0, out_valid}, 32'h0);

        out_ready = 1'b0;
        drive(2'b10, 4'b0111, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0);
        step();
        check("bp_ready1", {31'b0, in_ready}, 32'h1);
        drive(2'b10, 4'b0110, 1'b0, 32'h0F0F0000, 32'h0000F0F0, 32'h0);
        step();
        check("bp_ready_low", {31'b0, in_ready}, 32'h0);
        check("bp_valid", {31'b0, out_valid}, 32'h1);
        check("bp_and", out_result, 32'hF000F000);
        drive(2'b10, 4'b0000, 1'b0, 32'h1, 32'h2, 32'h0);
        step();
        check("bp_hold_ready", {31'b0, in_ready}, 32'h0);
        check("bp_hold_result", out_result, 32'hF000F000);
        check("bp_hold_op", {29'b0, alu_op}, 32'h1);
        check("bp_hold_a", alu_a, 32'h0F0F0000);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("bp_or", out_result, 32'h0F0FF0F0);
        check("bp_or_valid", {31'b0, out_valid}, 32'h1);
        step();
        check("bp_third", out_result, 32'h3);
        check("bp_third_valid", {31'b0, out_valid}, 32'h1);
        step();
        check("bp_no_dup", {31'b0, out_valid}, 32'h0);

        drive(2'b11, 4'b0000, 1'b0, 32'h1, 32'h1, 32'h0);
        step();
        in_valid = 1'b0;
        step();
        check("aluop11_result", out_result, 32'h2);
        check("aluop11_err", {31'b0, out_err}, 32'h1);
        step();

        out_ready = 1'b0;
        drive(2'b10, 4'b0101, 1'b0, 32'h10, 32'h20, 32'h0);
        step();
        check("ill_alu_op", {29'b0, alu_op}, 32'h2);
        drive(2'b10, 4'b1000, 1'b0, 32'h100, 32'h1, 32'h0);
        step();
        in_valid = 1'b0;
        check("ill_err", {31'b0, out_err}, 32'h1);
        check("ill_result", out_result, 32'h30);
        check("ill_full", {31'b0, in_ready}, 32'h0);
        rst_n     = 1'b0;
        out_ready = 1'b1;
        step();
        check("mid_rst_valid", {31'b0, out_valid}, 32'h0);
        check("mid_rst_result", out_result, 32'h0);
        check("mid_rst_err", {31'b0, out_err}, 32'h0);
        rst_n = 1'b1;
        step();
        check("flushed1", {31'b0, out_valid}, 32'h0);
        step();
        check("flushed2", {31'b0, out_valid}, 32'h0);
        check("flushed_result", out_result, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Two-register pipeline slice around the combinational 32-bit ALU (op 000 AND, 001 OR, 010 ADD, 110 SUB; zero flag `ex`).
- Accepts decoded-instruction fields and register operands from the decode stage, then decodes ALUOp/funct into the 3-bit ALU op.
- Selects the B operand (register or immediate) and registers A/B/op (ID/EX) to drive the ALU.
- Captures the ALU result and zero flag into an EX/WB register.
- Valid/ready handshake on both sides; throughput one op per cycle.

Parameters:
- WIDTH, 32, operand/result width (ALU is fixed at 32; other values unsupported).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  upstream has an instruction.
- in_ready  output  1  stage can accept this cycle.
- in_aluop  input  2  00 = load/store (ADD), 01 = branch (SUB), 10 = R-type (use funct), 11 = illegal.
- in_funct  input  4  {funct7[5], funct3}.
- in_alusrc  input  1  1 selects in_imm as B, 0 selects in_rs2.
- in_rs1  input  32  operand A.
- in_rs2  input  32  register operand B.
- in_imm  input  32  sign-extended immediate.
- alu_a  output  32  registered A to ALU.
- alu_b  output  32  registered B to ALU.
- alu_op  output  3  registered ALU op.
- alu_z  input  32  ALU result (combinational from alu_a/alu_b/alu_op).
- alu_ex  input  1  ALU zero flag.
- out_valid  output  1  result register holds valid data.
- out_ready  input  1  downstream consumes when high with out_valid.
- out_result  output  32  captured alu_z.
- out_zero  output  1  captured alu_ex.
- out_err  output  1  captured illegal-decode flag.

Behaviour:
- Reset (rst_n low at a rising edge): s1_valid = 0, s2_valid = 0, alu_a = alu_b = 0, alu_op = 3'b010, out_result = 0, out_zero = 0, out_err = 0. Reset overrides all handshakes, and reset mid-operation discards any in-flight data.
- Decode:
  - aluop 00 → 010.
  - aluop 01 → 110.
  - aluop 10 with funct 0000 → 010; 1000 → 110; 0111 → 000; 0110 → 001.
  - Any other funct, or aluop 11 → op 010 with err = 1. The instruction still flows through the pipeline; it is not dropped.
- B select: alu_b ← in_alusrc ? in_imm : in_rs2.
- Control signals:
  - s2_free = !s2_valid || out_ready.
  - s1_adv = s1_valid && s2_free.
  - in_ready = !s1_valid || s2_free (combinational; no dependency on in_valid).
- Stage 1: on in_valid && in_ready, load alu_a/alu_b/alu_op/err1 and set s1_valid = 1. Otherwise, if s1_adv, clear s1_valid. Otherwise hold. When stage 1 is not loading, alu_a/b/op hold their values.
- Stage 2: if s1_adv, load out_result ← alu_z, out_zero ← alu_ex, out_err ← err1, and set s2_valid = 1. Otherwise, if out_valid && out_ready, clear s2_valid. Otherwise hold all fields stable.
- out_valid = s2_valid.
- Latency: an op accepted at edge N appears on out_valid after edge N+1 (2-register latency, 1 cycle of ALU evaluation).
- Full throughput: with out_ready held high, one op completes per cycle back-to-back.
- Backpressure: with out_ready low and both stages full, in_ready = 0, and all registers and outputs hold stable.
- Simultaneous events: when out_ready is asserted while full, stage 2 reloads from stage 1 and stage 1 reloads from the input on the same edge, with no bubble.
- Arithmetic: ADD/SUB wrap modulo 2^32; the stage performs no overflow detection.

Decomposition:
- Shared package alu_pkg:
  - ALU_AND = 3'b000, ALU_OR = 3'b001, ALU_ADD = 3'b010, ALU_SUB = 3'b110.
  - ALUOP_MEM = 2'b00, ALUOP_BR = 2'b01, ALUOP_R = 2'b10.
  - Funct codes F_ADD = 4'b0000, F_SUB = 4'b1000, F_AND = 4'b0111, F_OR = 4'b0110.
- One combinational sub-module, alu_ctrl (aluop, funct → op, err), reused by later decode stages.

Test Plan:
- Reset with in_valid = 1 held: out_valid = 0, in_ready = 1, alu_op = 010, all other outputs 0.
- Single R-type: rs1 = 0x0000_0005, rs2 = 0x0000_0003, funct 1000, alusrc 0 → two edges later out_result = 0x0000_0002, out_zero = 0, out_err = 0.
- Branch compare: aluop 01, rs1 = rs2 = 0xDEAD_BEEF → out_result = 0, out_zero = 1.
- Immediate and wrap-around: aluop 00, alusrc 1, rs1 = 0xFFFF_FFFF, imm = 0x0000_0001 → out_result = 0, out_zero = 1.
- Backpressure: stream AND (0xF0F0_F0F0 & 0xFF00_FF00 = 0xF000_F000), then OR (0x0F0F_0000 | 0x0000_F0F0 = 0x0F0F_F0F0), then a third op, with out_ready = 0.
  - Expected: in_ready drops after two accepts, and out_result holds 0xF000_F000.
  - On releasing out_ready: results drain in order with no loss or duplication.
- Illegal decode, then reset mid-flight:
  - funct 0101 with aluop 10 → out_err = 1 and out_result = rs1 + rs2.
  - Asserting rst_n = 0 while both stages are valid → next edge out_valid = 0, and the in-flight result never appears.
